// File: rtl/pmc_pkg.sv
// Shared encodings and helpers for the power/mode controller.
package pmc_pkg;

  typedef enum logic [1:0] {
    PS_OFF    = 2'd0,
    PS_ARMING = 2'd1,
    PS_ON     = 2'd2
  } pwr_state_e;

  // Widest mode vector the one-hot helper accepts; narrower vectors are zero-extended.
  localparam int unsigned MAX_MODES = 32;

  function automatic logic is_onehot(input logic [MAX_MODES-1:0] v);
    return (v != '0) && ((v & (v - MAX_MODES'(1))) == '0);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned     DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned     CW   = $clog2(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/power_mode_ctrl.sv
// Power/mode controller: debounced hold-to-start power FSM with a break-before-make
// one-hot drive-mode arbiter, idle auto-off and fault-forced shutdown.
module power_mode_ctrl
  import pmc_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned TICK_HZ        = 100,
  parameter int unsigned DEB_TICKS      = 2,
  parameter int unsigned HOLD_ON_TICKS  = 100,
  parameter int unsigned IDLE_OFF_TICKS = 1000,
  parameter int unsigned N_MODES        = 3
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               power_on_btn,
  input  logic               power_off_btn,
  input  logic [N_MODES-1:0] mode_sel,
  input  logic               activity,
  input  logic               fault_off,
  output logic               power_on_led,
  output logic [N_MODES-1:0] mode_led,
  output logic [N_MODES-1:0] mode_en,
  output logic [1:0]         pwr_state,
  output logic               mode_chg
);

  localparam int unsigned   NB        = N_MODES + 2;
  localparam int unsigned   DW        = $clog2(DEB_TICKS + 1);
  localparam int unsigned   HW        = $clog2(HOLD_ON_TICKS + 1);
  localparam int unsigned   IW        = (IDLE_OFF_TICKS == 0) ? 1 : $clog2(IDLE_OFF_TICKS + 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_ON_TICKS - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_OFF_TICKS);
  localparam bit            IDLE_EN   = (IDLE_OFF_TICKS != 0);

  logic tick;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .tick_o(tick)
  );

  logic [NB-1:0] raw, sync1_q, sync2_q, db;

  assign raw = {mode_sel, power_off_btn, power_on_btn};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: the accepted level follows once DEB_TICKS consecutive tick samples agree.
  for (genvar b = 0; b < NB; b++) begin : g_deb
    logic          samp_q, lvl_q;
    logic [DW-1:0] run_q, run_d;

    always_comb begin
      run_d = DW'(1);
      if (sync2_q[b] == samp_q) run_d = (run_q == DEB_MAX) ? run_q : run_q + DW'(1);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        samp_q <= 1'b0;
        run_q  <= '0;
        lvl_q  <= 1'b0;
      end else if (tick) begin
        samp_q <= sync2_q[b];
        run_q  <= run_d;
        if (run_d == DEB_MAX) lvl_q <= sync2_q[b];
      end
    end

    assign db[b] = lvl_q;
  end

  logic               on_db, off_db, sel_valid;
  logic [N_MODES-1:0] sel_db;

  assign on_db     = db[0];
  assign off_db    = db[1];
  assign sel_db    = db[NB-1:2];
  assign sel_valid = is_onehot(MAX_MODES'(sel_db));

  pwr_state_e         st_q, st_d;
  logic               rearm_q, rearm_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [N_MODES-1:0] mode_q, mode_d, mode_dly_q;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    st_d    = st_q;
    rearm_d = rearm_q;
    hold_d  = hold_q;
    idle_d  = idle_q;
    mode_d  = mode_q;

    if (activity) idle_d = '0;

    if (fault_off) begin
      st_d = PS_OFF;
    end else if (tick) begin
      case (st_q)
        PS_OFF: begin
          if (!on_db) begin
            rearm_d = 1'b1;
          end else if (!off_db && rearm_q) begin
            st_d   = PS_ARMING;
            hold_d = HW'(1);
          end
        end
        PS_ARMING: begin
          if (!on_db || off_db) begin
            st_d = PS_OFF;
          end else if (hold_q >= HOLD_LAST) begin
            st_d   = PS_ON;
            hold_d = '0;
            idle_d = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        PS_ON: begin
          if (off_db || (IDLE_EN && !activity && idle_q == IDLE_MAX)) begin
            st_d = PS_OFF;
          end else begin
            if (IDLE_EN && !activity && idle_q != IDLE_MAX) idle_d = idle_q + IW'(1);
            // A change between two valid modes passes through all-off for one tick.
            if (!sel_valid)              mode_d = '0;
            else if (mode_q == '0)       mode_d = sel_db;
            else if (sel_db != mode_q)   mode_d = '0;
          end
        end
        default: st_d = PS_OFF;
      endcase
    end

    // Leaving ARMING/ON drops the mode and blocks re-arming until the on button is released.
    if (st_q != PS_OFF && st_d == PS_OFF) begin
      rearm_d = 1'b0;
      mode_d  = '0;
      hold_d  = '0;
      idle_d  = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= PS_OFF;
      rearm_q    <= 1'b1;
      hold_q     <= '0;
      idle_q     <= '0;
      mode_q     <= '0;
      mode_dly_q <= '0;
    end else begin
      st_q       <= st_d;
      rearm_q    <= rearm_d;
      hold_q     <= hold_d;
      idle_q     <= idle_d;
      mode_q     <= mode_d;
      mode_dly_q <= mode_q;
    end
  end

  assign pwr_state    = st_q;
  assign power_on_led = (st_q == PS_ON);
  assign mode_en      = mode_q;
  assign mode_led     = mode_q;
  assign mode_chg     = (mode_q != mode_dly_q);

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Self-checking bench for power_mode_ctrl: table-driven settled-state vectors through a
// scoreboard queue, plus hand-written sequences for exact latencies and corner cases.
module tb_power_mode_ctrl;
  import pmc_pkg::*;

  localparam int TC = 10;  // clock cycles per tick (1000 Hz / 100 Hz)

  logic       sys_clk, rst_n;
  logic       power_on_btn, power_off_btn, activity, fault_off;
  logic [2:0] mode_sel;
  logic       power_on_led, mode_chg;
  logic [2:0] mode_led, mode_en;
  logic [1:0] pwr_state;

  power_mode_ctrl #(
    .CLK_HZ        (1000),
    .TICK_HZ       (100),
    .DEB_TICKS     (2),
    .HOLD_ON_TICKS (5),
    .IDLE_OFF_TICKS(20),
    .N_MODES       (3)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .power_on_btn (power_on_btn),
    .power_off_btn(power_off_btn),
    .mode_sel     (mode_sel),
    .activity     (activity),
    .fault_off    (fault_off),
    .power_on_led (power_on_led),
    .mode_led     (mode_led),
    .mode_en      (mode_en),
    .pwr_state    (pwr_state),
    .mode_chg     (mode_chg)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string      tag;
    logic       on, off, act;
    logic [2:0] sel;
    int         ticks;
    logic [1:0] st;
    logic [2:0] mode;
  } vec_t;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [2:0] mode;
  } exp_t;

  vec_t tbl[16];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * TC) @(negedge sys_clk);
  endtask

  // Called right after power_on_btn rises; returns cycle counts to ARMING and ON (-1 = not seen).
  task automatic measure_on(input int budget, output int t_arm, output int t_on);
    int cyc;
    cyc   = 0;
    t_arm = -1;
    t_on  = -1;
    while (t_on < 0 && cyc < budget) begin
      @(negedge sys_clk);
      cyc++;
      if (pwr_state == PS_ARMING && t_arm < 0) t_arm = cyc;
      if (power_on_led && t_on < 0) t_on = cyc;
    end
  endtask

  // Counts mode_chg pulses over n cycles and how many of those cycles had mode_en == 0.
  task automatic watch_modes(input int n, output int pulses, output int zeros);
    pulses = 0;
    zeros  = 0;
    repeat (n) begin
      @(negedge sys_clk);
      if (mode_chg) pulses++;
      if (mode_en == 3'b000) zeros++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t_arm, t_on, pulses, zeros, bad, cyc;
    logic seen_on;
    exp_t e;

    //               tag             on    off   act   sel     tk  state      mode
    tbl[0]  = '{"power_up",       1'b1, 1'b0, 1'b1, 3'b000, 10, PS_ON,  3'b000};
    tbl[1]  = '{"sel_001",        1'b0, 1'b0, 1'b1, 3'b001,  5, PS_ON,  3'b001};
    tbl[2]  = '{"sel_100_bbm",    1'b0, 1'b0, 1'b1, 3'b100,  5, PS_ON,  3'b100};
    tbl[3]  = '{"sel_011_bad",    1'b0, 1'b0, 1'b1, 3'b011,  5, PS_ON,  3'b000};
    tbl[4]  = '{"sel_010",        1'b0, 1'b0, 1'b1, 3'b010,  5, PS_ON,  3'b010};
    tbl[5]  = '{"sel_000_bad",    1'b0, 1'b0, 1'b1, 3'b000,  5, PS_ON,  3'b000};
    tbl[6]  = '{"sel_010_again",  1'b0, 1'b0, 1'b1, 3'b010,  5, PS_ON,  3'b010};
    tbl[7]  = '{"off_btn",        1'b0, 1'b1, 1'b1, 3'b010,  6, PS_OFF, 3'b000};
    tbl[8]  = '{"repower",        1'b1, 1'b0, 1'b1, 3'b010, 10, PS_ON,  3'b010};
    tbl[9]  = '{"both_in_on",     1'b1, 1'b1, 1'b1, 3'b010,  6, PS_OFF, 3'b000};
    tbl[10] = '{"held_no_rearm",  1'b1, 1'b0, 1'b1, 3'b010, 10, PS_OFF, 3'b000};
    tbl[11] = '{"release_on",     1'b0, 1'b0, 1'b1, 3'b010,  5, PS_OFF, 3'b000};
    tbl[12] = '{"both_from_off",  1'b1, 1'b1, 1'b1, 3'b010, 10, PS_OFF, 3'b000};
    tbl[13] = '{"both_release",   1'b0, 1'b0, 1'b1, 3'b010,  5, PS_OFF, 3'b000};
    tbl[14] = '{"idle_start",     1'b1, 1'b0, 1'b0, 3'b010, 10, PS_ON,  3'b010};
    tbl[15] = '{"idle_timeout",   1'b1, 1'b0, 1'b0, 3'b010, 25, PS_OFF, 3'b000};

    rst_n = 1'b0;
    power_on_btn = 1'b0; power_off_btn = 1'b0; activity = 1'b0; fault_off = 1'b0;
    mode_sel = 3'b000;
    repeat (3) @(negedge sys_clk);
    check("reset_state", pwr_state, PS_OFF);
    check("reset_led", power_on_led, 1'b0);
    check("reset_mode_en", mode_en, 3'b000);
    check("reset_mode_chg", mode_chg, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge sys_clk);
      power_on_btn  = tbl[i].on;
      power_off_btn = tbl[i].off;
      activity      = tbl[i].act;
      mode_sel      = tbl[i].sel;
      sb_q.push_back('{tbl[i].tag, tbl[i].st, tbl[i].mode});
      ticks(tbl[i].ticks);
      e = sb_q.pop_front();
      check({e.tag, "/state"}, pwr_state, e.st);
      check({e.tag, "/led"}, power_on_led, (e.st == PS_ON));
      check({e.tag, "/mode_en"}, mode_en, e.mode);
      check({e.tag, "/mode_led"}, mode_led, e.mode);
    end
    check("scoreboard_drained", sb_q.size(), 0);

    power_on_btn = 1'b0; activity = 1'b1; mode_sel = 3'b000;
    ticks(5);

    // Release after 3 ticks: never reaches ON.
    power_on_btn = 1'b1;
    repeat (3 * TC) @(negedge sys_clk);
    power_on_btn = 1'b0;
    seen_on = 1'b0;
    repeat (15 * TC) begin
      @(negedge sys_clk);
      if (power_on_led) seen_on = 1'b1;
    end
    check("rel3_never_on", seen_on, 1'b0);
    check("rel3_state", pwr_state, PS_OFF);
    ticks(5);

    // Press-to-ON latency: ARMING after sync + 2 debounce ticks + 1, ON exactly 4 ticks later.
    power_on_btn = 1'b1;
    measure_on(200, t_arm, t_on);
    check_rng("hold_arming_latency", t_arm, 23, 32);
    check_rng("hold_on_latency", t_on, 63, 72);
    check_rng("hold_arming_to_on", t_on - t_arm, 40, 40);
    power_on_btn = 1'b0;
    ticks(3);

    // Mode entry: one pulse; mode switch: break for exactly one tick, two pulses.
    mode_sel = 3'b001;
    watch_modes(50, pulses, zeros);
    check("chg_entry_mode", mode_en, 3'b001);
    check("chg_entry_pulses", pulses, 1);
    mode_sel = 3'b100;
    watch_modes(60, pulses, zeros);
    check("chg_switch_mode", mode_en, 3'b100);
    check("chg_switch_pulses", pulses, 2);
    check("chg_break_cycles", zeros, TC);

    // One-tick glitch on mode_sel is rejected.
    mode_sel = 3'b010;
    repeat (TC) @(negedge sys_clk);
    mode_sel = 3'b100;
    bad = 0;
    pulses = 0;
    repeat (60) begin
      @(negedge sys_clk);
      if (mode_en != 3'b100) bad++;
      if (mode_chg) pulses++;
    end
    check("glitch_mode_disturbed_cycles", bad, 0);
    check("glitch_pulses", pulses, 0);

    // Activity every 15 ticks keeps the 20-tick idle timer from expiring.
    activity = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ticks(15);
      check($sformatf("idle_keepalive_%0d", k), pwr_state, PS_ON);
      activity = 1'b1;
      @(negedge sys_clk);
      activity = 1'b0;
    end
    activity = 1'b1;

    // Fault forces OFF on the next edge; held button must be released before re-arming.
    power_on_btn = 1'b1;
    ticks(5);
    check("fault_pre_state", pwr_state, PS_ON);
    fault_off = 1'b1;
    @(negedge sys_clk);
    fault_off = 1'b0;
    check("fault_state", pwr_state, PS_OFF);
    check("fault_led", power_on_led, 1'b0);
    check("fault_mode_en", mode_en, 3'b000);
    check("fault_mode_chg", mode_chg, 1'b1);
    ticks(10);
    check("fault_held_no_rearm", pwr_state, PS_OFF);
    power_on_btn = 1'b0;
    ticks(5);
    power_on_btn = 1'b1;
    ticks(10);
    check("fault_rearm_on", pwr_state, PS_ON);
    power_on_btn = 1'b0;

    // Async reset in the middle of ARMING clears everything; the next hold restarts from scratch.
    power_off_btn = 1'b1;
    ticks(6);
    check("pre_reset_off", pwr_state, PS_OFF);
    power_off_btn = 1'b0;
    ticks(5);
    power_on_btn = 1'b1;
    cyc = 0;
    while (pwr_state != PS_ARMING && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
    end
    check("mid_arming_reached", pwr_state, PS_ARMING);
    repeat (15) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_state", pwr_state, PS_OFF);
    check("async_reset_led", power_on_led, 1'b0);
    check("async_reset_mode_en", mode_en, 3'b000);
    check("async_reset_mode_chg", mode_chg, 1'b0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    measure_on(200, t_arm, t_on);
    check_rng("post_reset_arming", t_arm, 30, 30);
    check_rng("post_reset_on", t_on, 70, 70);
    power_on_btn = 1'b0;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
